// File: rtl/voice_allocator.sv
// voice_allocator: 4-voice note allocator with LRU stealing and a time-sliced
// frame scheduler that presents one voice per slot to a shared generator.
module voice_allocator #(
    parameter int SLOT_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       note_on,
    input  logic       note_off,
    input  logic [6:0] note,
    input  logic [6:0] velocity,
    input  logic       sample_tick,
    output logic [3:0] voice_active,
    output logic [1:0] gen_voice,
    output logic [6:0] gen_note,
    output logic [6:0] gen_velocity,
    output logic       gen_gate,
    output logic       gen_strobe,
    output logic       frame_done,
    output logic       busy,
    output logic       steal,
    output logic       overrun
);
    typedef enum logic {IDLE, SLOT} state_t;
    state_t     state, state_nx;
    logic [7:0] cnt, cnt_nx;
    logic [1:0] slot, slot_nx;
    logic       last;
    logic [3:0] active;
    logic [6:0] v_note [4];
    logic [6:0] v_vel [4];
    logic [1:0] rank [4];
    logic       alloc, release_n, stealing;
    logic [3:0] hit;
    logic [1:0] tgt;
    logic [6:0] snap_note, snap_vel;
    logic       snap_gate;

    // Target choice: retrigger a matching active voice, else lowest free, else oldest.
    always_comb begin
        alloc = note_on && velocity != 7'd0;
        release_n = (note_on && velocity == 7'd0) || (note_off && !note_on);
        hit = '0;
        tgt = '0;
        stealing = 1'b0;
        for (int i = 0; i < 4; i++) hit[i] = active[i] && v_note[i] == note;
        if (hit != 4'd0) begin
            for (int i = 3; i >= 0; i--) if (hit[i]) tgt = 2'(i);
        end else if (active != 4'hf) begin
            for (int i = 3; i >= 0; i--) if (!active[i]) tgt = 2'(i);
        end else begin
            stealing = 1'b1;
            for (int i = 0; i < 4; i++) if (rank[i] == 2'd3) tgt = 2'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            active <= '0;
            steal <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                v_note[i] <= '0;
                v_vel[i] <= '0;
                rank[i] <= 2'(i);
            end
        end else begin
            steal <= alloc && stealing;
            if (alloc) begin
                v_note[tgt] <= note;
                v_vel[tgt] <= velocity;
                active[tgt] <= 1'b1;
                for (int i = 0; i < 4; i++)
                    if (2'(i) == tgt) rank[i] <= 2'd0;
                    else if (rank[i] < rank[tgt]) rank[i] <= rank[i] + 2'd1;
            end else if (release_n) begin
                active <= active & ~hit;
            end
        end
    end

    assign last = cnt == 8'(SLOT_CYCLES - 1);

    always_comb begin
        state_nx = state;
        cnt_nx = cnt;
        slot_nx = slot;
        if (state == IDLE) begin
            if (sample_tick) begin
                state_nx = SLOT;
                cnt_nx = '0;
                slot_nx = '0;
            end
        end else if (last) begin
            cnt_nx = '0;
            slot_nx = slot + 2'd1;
            if (slot == 2'd3) state_nx = IDLE;
        end else begin
            cnt_nx = cnt + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            slot <= '0;
            frame_done <= 1'b0;
            overrun <= 1'b0;
            snap_note <= '0;
            snap_vel <= '0;
            snap_gate <= 1'b0;
        end else begin
            state <= state_nx;
            cnt <= cnt_nx;
            slot <= slot_nx;
            frame_done <= state == SLOT && last && slot == 2'd3;
            overrun <= sample_tick && state == SLOT;
            if (gen_strobe) begin
                snap_note <= v_note[slot];
                snap_vel <= v_vel[slot];
                snap_gate <= active[slot];
            end
        end
    end

    // First slot cycle shows live state; the rest of the slot replays the snapshot taken then.
    assign busy = state == SLOT;
    assign gen_strobe = busy && cnt == 8'd0;
    assign gen_voice = busy ? slot : 2'd0;
    assign gen_note = !busy ? 7'd0 : gen_strobe ? v_note[slot] : snap_note;
    assign gen_velocity = !busy ? 7'd0 : gen_strobe ? v_vel[slot] : snap_vel;
    assign gen_gate = busy && (gen_strobe ? active[slot] : snap_gate);
    assign voice_active = active;
endmodule

// File: tb/tb_voice_allocator.sv
// tb_voice_allocator: directed and random stimulus checked every cycle against
// a behavioural model (LRU order queue, frame offset arithmetic).
module tb_voice_allocator;
    localparam int SC = 8;
    logic       clk = 1'b0;
    logic       rst = 1'b0, note_on = 1'b0, note_off = 1'b0, sample_tick = 1'b0;
    logic [6:0] note = '0, velocity = '0;
    logic [3:0] voice_active;
    logic [1:0] gen_voice;
    logic [6:0] gen_note, gen_velocity;
    logic       gen_gate, gen_strobe, frame_done, busy, steal, overrun;

    voice_allocator #(.SLOT_CYCLES(SC)) dut (
        .clk(clk), .rst(rst), .note_on(note_on), .note_off(note_off), .note(note),
        .velocity(velocity), .sample_tick(sample_tick), .voice_active(voice_active),
        .gen_voice(gen_voice), .gen_note(gen_note), .gen_velocity(gen_velocity),
        .gen_gate(gen_gate), .gen_strobe(gen_strobe), .frame_done(frame_done),
        .busy(busy), .steal(steal), .overrun(overrun)
    );

    always #10 clk = ~clk;

    int checks = 0, errors = 0;
    bit m_act [4];
    int m_note [4], m_vel [4];
    int lru [$];
    bit m_frame, m_fd, m_ov, m_steal;
    int m_off, s_note, s_vel, s_gate;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) begin
            m_act[i] = 0;
            m_note[i] = 0;
            m_vel[i] = 0;
        end
        lru = {0, 1, 2, 3};
        m_frame = 0; m_off = 0; m_fd = 0; m_ov = 0; m_steal = 0;
        s_note = 0; s_vel = 0; s_gate = 0;
    endfunction

    // lru holds voices newest-first; the tail is the steal victim.
    function automatic void apply_note(bit on, bit off_s, int n, int v);
        int tgt = -1;
        if (on && v != 0) begin
            for (int i = 0; i < 4; i++) if (tgt < 0 && m_act[i] && m_note[i] == n) tgt = i;
            for (int i = 0; i < 4; i++) if (tgt < 0 && !m_act[i]) tgt = i;
            if (tgt < 0) begin
                tgt = lru[lru.size() - 1];
                m_steal = 1;
            end
            m_act[tgt] = 1; m_note[tgt] = n; m_vel[tgt] = v;
            for (int k = 0; k < lru.size(); k++)
                if (lru[k] == tgt) begin
                    lru.delete(k);
                    break;
                end
            lru.push_front(tgt);
        end else if (on || off_s) begin
            for (int i = 0; i < 4; i++) if (m_act[i] && m_note[i] == n) m_act[i] = 0;
        end
    endfunction

    task automatic step(input bit r, input bit on, input bit off_s, input int n, input int v, input bit t);
        int exp_act, sv;
        bit first;
        rst = r; note_on = on; note_off = off_s; note = 7'(n); velocity = 7'(v); sample_tick = t;
        @(posedge clk);
        if (r) model_reset();
        else begin
            m_ov = t && m_frame;
            m_fd = m_frame && m_off == 4 * SC - 1;
            m_steal = 0;
            if (m_frame) begin
                m_off++;
                if (m_off == 4 * SC) begin
                    m_frame = 0;
                    m_off = 0;
                end
            end else if (t) begin
                m_frame = 1;
                m_off = 0;
            end
            apply_note(on, off_s, n, v);
        end
        #1;
        exp_act = 0;
        for (int i = 0; i < 4; i++) exp_act += int'(m_act[i]) << i;
        first = m_frame && m_off % SC == 0;
        sv = m_off / SC;
        if (first) begin
            s_note = m_note[sv]; s_vel = m_vel[sv]; s_gate = int'(m_act[sv]);
        end
        chk("voice_active", voice_active, exp_act);
        chk("steal", steal, m_steal);
        chk("frame_done", frame_done, m_fd);
        chk("overrun", overrun, m_ov);
        chk("busy", busy, m_frame);
        chk("gen_strobe", gen_strobe, first);
        chk("gen_voice", gen_voice, m_frame ? sv : 0);
        chk("gen_note", gen_note, m_frame ? s_note : 0);
        chk("gen_velocity", gen_velocity, m_frame ? s_vel : 0);
        chk("gen_gate", gen_gate, m_frame ? s_gate : 0);
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic on(input int n, input int v);
        step(0, 1, 0, n, v, 0);
    endtask

    initial begin
        int busy_cnt;
        step(1, 0, 0, 0, 0, 0);
        chk("reset_active", voice_active, 0);
        on(60, 100);
        chk("one_voice", voice_active, 4'b0001);
        on(64, 80);
        chk("two_voices", voice_active, 4'b0011);
        on(62, 50);
        on(65, 40);
        on(67, 90);
        chk("steal_pulse", steal, 1);
        chk("full_after_steal", voice_active, 4'b1111);
        idle(1);
        chk("steal_one_cycle", steal, 0);
        // Frame with a stray tick at offset 10; voice 0 must now carry note 67.
        step(0, 0, 0, 0, 0, 1);
        chk("slot0_note", gen_note, 67);
        busy_cnt = 1;
        for (int k = 1; k < 40; k++) begin
            step(0, 0, 0, 0, 0, k == 10);
            if (k == 10) chk("overrun_seen", overrun, 1);
            if (busy) busy_cnt++;
        end
        chk("frame_length", busy_cnt, 4 * SC);
        on(64, 80);
        chk("retrigger_no_steal", steal, 0);
        // Velocity-zero note-on releases voice 1.
        step(1, 0, 0, 0, 0, 0);
        on(61, 10);
        on(60, 20);
        on(60, 0);
        chk("vel0_release", voice_active, 4'b0001);
        step(0, 1, 1, 61, 30, 0);
        chk("on_beats_off", voice_active, 4'b0001);
        // Release voice 2 in the middle of slot 2; gate holds until next frame.
        on(62, 33);
        on(63, 44);
        step(0, 0, 0, 0, 0, 1);
        idle(2 * SC + 2);
        step(0, 0, 1, 63, 0, 0);
        chk("gate_held", gen_gate, 1);
        idle(3 * SC);
        step(0, 0, 0, 0, 0, 1);
        idle(2 * SC);
        chk("gate_dropped", gen_gate, 0);
        idle(2 * SC);
        // Reset mid-frame at offset 13 with three voices active.
        step(1, 0, 0, 0, 0, 0);
        on(70, 1); on(71, 2); on(72, 3);
        step(0, 0, 0, 0, 0, 1);
        idle(13);
        step(1, 1, 0, 80, 80, 1);
        chk("reset_midframe", {voice_active, busy, gen_strobe, gen_note}, 0);
        step(0, 0, 0, 0, 0, 1);
        chk("clean_restart", gen_voice, 0);
        idle(4 * SC + 2);
        for (int k = 0; k < 1500; k++) begin
            int r = int'($urandom_range(0, 299));
            bit o = $urandom_range(0, 3) == 0;
            bit f = $urandom_range(0, 5) == 0;
            int n = 60 + int'($urandom_range(0, 6));
            int v = $urandom_range(0, 7) == 0 ? 0 : int'($urandom_range(1, 127));
            step(r == 0, o, f, n, v, $urandom_range(0, 19) == 0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
